// File: rtl/simon_game.sv
// Simon memory game core: pattern sequence memory plus Input/Playback/Repeat/Done controller.
// Outputs are combinational from registered state and the live pattern input; no handshake, advances every pclk edge.
module simon_game #(
    parameter int PAT_W = 4,
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             level,
    input  logic [PAT_W-1:0] pattern,
    output logic [PAT_W-1:0] pattern_leds,
    output logic [2:0]       mode_leds
);

    typedef enum logic [1:0] {
        S_INPUT,
        S_PLAYBACK,
        S_REPEAT,
        S_DONE
    } mode_t;

    mode_t            mode;
    logic [IDX_W:0]   n;
    logic [IDX_W-1:0] i;
    logic [PAT_W-1:0] mem [DEPTH];

    logic             pattern_onehot;
    logic             pattern_valid;
    logic             at_last;
    logic             seq_full;
    logic             guess_ok;
    logic             mem_wr;
    logic [PAT_W-1:0] mem_rd_dat;

    assign pattern_onehot = (pattern != '0) && ((pattern & (pattern - PAT_W'(1))) == '0);
    assign pattern_valid  = level ? pattern_onehot : 1'b1;
    assign at_last        = ({1'b0, i} == (n - (IDX_W+1)'(1)));
    assign seq_full       = (n == (IDX_W+1)'(DEPTH));
    assign mem_rd_dat     = mem[i];
    assign guess_ok       = (pattern == mem_rd_dat);
    assign mem_wr         = (mode == S_INPUT) && pattern_valid && !rst;

    // Sequence memory carries no reset; entries beyond n are never read.
    always_ff @(posedge pclk) begin
        if (mem_wr) begin
            mem[n[IDX_W-1:0]] <= pattern;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            mode <= S_INPUT;
            n    <= '0;
            i    <= '0;
        end else begin
            case (mode)
                S_INPUT: begin
                    if (pattern_valid) begin
                        n    <= n + (IDX_W+1)'(1);
                        i    <= '0;
                        mode <= S_PLAYBACK;
                    end
                end
                S_PLAYBACK: begin
                    if (at_last) begin
                        i    <= '0;
                        mode <= S_REPEAT;
                    end else begin
                        i <= i + IDX_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (!guess_ok) begin
                        i    <= '0;
                        mode <= S_DONE;
                    end else if (at_last) begin
                        i    <= '0;
                        mode <= seq_full ? S_DONE : S_INPUT;
                    end else begin
                        i <= i + IDX_W'(1);
                    end
                end
                default: begin
                    // Game over: replay the stored sequence in a loop until reset.
                    if (at_last) begin
                        i <= '0;
                    end else begin
                        i <= i + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        mode_leds    = 3'b111;
        pattern_leds = mem_rd_dat;
        case (mode)
            S_INPUT: begin
                mode_leds    = 3'b001;
                pattern_leds = pattern;
            end
            S_PLAYBACK: begin
                mode_leds = 3'b010;
            end
            S_REPEAT: begin
                mode_leds    = 3'b100;
                pattern_leds = pattern;
            end
            default: begin
                mode_leds = 3'b111;
            end
        endcase
    end

endmodule

// File: tb/tb_simon_game.sv
// Randomized scoreboard bench for simon_game against a queue-based game model.
module tb_simon_game;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       level = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic [3:0] pattern_leds;
    logic [2:0] mode_leds;

    simon_game dut (
        .pclk         (pclk),
        .rst          (rst),
        .level        (level),
        .pattern      (pattern),
        .pattern_leds (pattern_leds),
        .mode_leds    (mode_leds)
    );

    always #5 pclk = ~pclk;

    localparam int M_INPUT = 0, M_PLAY = 1, M_REPEAT = 2, M_DONE = 3;
    localparam int MAX_LEN = 64;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [6:0] exp_q[$];

    // Reference game state: the stored sequence, current mode, current position.
    int         seq[$];
    int         m_mode = M_INPUT;
    int         m_idx = 0;
    logic       lvl = 1'b0;

    function automatic logic [2:0] mode_code(input int md);
        case (md)
            M_INPUT:  return 3'b001;
            M_PLAY:   return 3'b010;
            M_REPEAT: return 3'b100;
            default:  return 3'b111;
        endcase
    endfunction

    // Drive one pclk edge worth of inputs, advance the model, queue the expected LEDs.
    task automatic step(input logic r, input logic l, input logic [3:0] p);
        logic [3:0] pl;
        @(negedge pclk);
        rst     = r;
        level   = l;
        pattern = p;
        cyc++;
        if (r) begin
            m_mode = M_INPUT;
            seq.delete();
            m_idx = 0;
        end else begin
            case (m_mode)
                M_INPUT: begin
                    if (!l || $countones(p) == 1) begin
                        seq.push_back(int'(p));
                        m_idx  = 0;
                        m_mode = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (m_idx == seq.size() - 1) begin
                        m_idx  = 0;
                        m_mode = M_REPEAT;
                    end else begin
                        m_idx++;
                    end
                end
                M_REPEAT: begin
                    if (int'(p) != seq[m_idx]) begin
                        m_idx  = 0;
                        m_mode = M_DONE;
                    end else if (m_idx == seq.size() - 1) begin
                        m_idx  = 0;
                        m_mode = (seq.size() == MAX_LEN) ? M_DONE : M_INPUT;
                    end else begin
                        m_idx++;
                    end
                end
                default: begin
                    m_idx = (m_idx == seq.size() - 1) ? 0 : m_idx + 1;
                end
            endcase
        end
        if (m_mode == M_INPUT || m_mode == M_REPEAT) pl = p;
        else pl = 4'(seq[m_idx]);
        exp_q.push_back({mode_code(m_mode), pl});
    endtask

    task automatic play_game(input bit perfect, input int max_cyc);
        logic       r;
        logic [3:0] p;
        for (int k = 0; k < max_cyc; k++) begin
            r = !perfect && ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) lvl = ~lvl;
            p = 4'($urandom_range(0, 15));
            if (m_mode == M_REPEAT && (perfect || $urandom_range(0, 19) != 0))
                p = 4'(seq[m_idx]);
            else if (m_mode == M_INPUT && lvl && $urandom_range(0, 1) == 0)
                p = 4'(1 << $urandom_range(0, 3));
            step(r, lvl, p);
            if (m_mode == M_DONE) begin
                for (int d = 0; d < 2 * seq.size() + 3; d++)
                    step(1'b0, lvl, 4'($urandom_range(0, 15)));
                break;
            end
        end
    endtask

    // Monitor: compare every post-edge output against the oldest queued expectation.
    initial begin
        logic [6:0] e;
        forever begin
            @(posedge pclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({mode_leds, pattern_leds} !== e) begin
                    errors++;
                    $display("FAIL leds t=%0t got mode_leds=%b pattern_leds=%b expected mode_leds=%b pattern_leds=%b",
                             $time, mode_leds, pattern_leds, e[6:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        step(1'b1, 1'b0, 4'b0001);
        step(1'b1, 1'b1, 4'b1010);

        // Directed opening: one entry, replay, correct guess, then a hard-level reject.
        step(1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b1, 4'b1010);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, 4'b0101);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0100);
        for (int d = 0; d < 5; d++) step(1'b0, 1'b0, 4'b1111);

        step(1'b1, 1'b0, 4'b0000);
        play_game(1'b1, 6000);

        for (int g = 0; g < 20; g++) begin
            step(1'b1, lvl, 4'($urandom_range(0, 15)));
            play_game(1'b0, 1500);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge pclk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
